// File: rtl/router_out_arbiter.sv
// Output stage of one router port: round-robin arbitration over head flits,
// wormhole grant lock held until the tail flit, and a small circular FIFO
// driving the outgoing link.
//
// Lock FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   UNLOCKED | no packet in flight; head/head+tail flits arbitrate round-robin
//   LOCKED   | packet from grant_o in flight; only that input may send
module router_out_arbiter #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_IN       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [N_IN-1:0]              fin_valid_i,
  input  logic [N_IN*FLIT_WIDTH-1:0]   fin_data_i,
  output logic [N_IN-1:0]              fin_ready_o,
  output logic                         fout_valid_o,
  output logic [FLIT_WIDTH-1:0]        fout_data_o,
  input  logic                         fout_ready_i,
  output logic                         lock_o,
  output logic [$clog2(N_IN)-1:0]      grant_o
);

  localparam int IDXW = $clog2(N_IN);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_IN - 1);
  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

  localparam logic [1:0] FT_HEAD     = 2'b00;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t     state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

  logic [FLIT_WIDTH-1:0] in_flit [N_IN];
  logic [1:0]            in_type [N_IN];
  logic [N_IN-1:0]       in_is_head;

  logic [IDXW-1:0]       sel;
  logic                  sel_valid;
  int                    scan_idx;
  logic [IDXW-1:0]       cand;

  logic                  push;
  logic                  pop;
  logic [FLIT_WIDTH-1:0] push_flit;
  logic [1:0]            push_type;

  logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q;
  logic                  fifo_full;
  logic                  fifo_empty;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDXW'(1);
  endfunction

  for (genvar g = 0; g < N_IN; g++) begin : g_unpack
    assign in_flit[g]    = fin_data_i[g*FLIT_WIDTH +: FLIT_WIDTH];
    assign in_type[g]    = in_flit[g][FLIT_WIDTH-1 -: 2];
    assign in_is_head[g] = (in_type[g] == FT_HEAD) || (in_type[g] == FT_HEADTAIL);
  end

  // Select the candidate input: the locked input, or the first valid head from rr_ptr onward.
  always_comb begin
    sel       = grant_q;
    sel_valid = 1'b0;
    scan_idx  = 0;
    cand      = '0;
    if (state_q == LOCKED) begin
      sel       = grant_q;
      sel_valid = fin_valid_i[grant_q];
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        scan_idx = int'(rr_ptr_q) + k;
        if (scan_idx >= N_IN) scan_idx = scan_idx - N_IN;
        cand = IDXW'(scan_idx);
        if (!sel_valid && fin_valid_i[cand] && in_is_head[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  // A full FIFO refuses the push even if it is being drained this cycle, which keeps
  // fin_ready_o independent of fout_ready_i.
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = sel_valid && !fifo_full;
  assign pop        = !fifo_empty && fout_ready_i;
  assign push_flit  = in_flit[sel];
  assign push_type  = in_type[sel];

  // One-hot ready towards the selected input only.
  always_comb begin
    fin_ready_o = '0;
    if (push) fin_ready_o[sel] = 1'b1;
  end

  // Lock FSM next state, grant and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      UNLOCKED: begin
        if (push) begin
          grant_d = sel;
          if (push_type == FT_HEAD) begin
            state_d = LOCKED;
          end else if (push_type == FT_HEADTAIL) begin
            rr_ptr_d = next_idx(sel);
          end
        end
      end
      LOCKED: begin
        // Stray heads from the locked input pass through without touching the lock.
        if (push && (push_type == FT_TAIL)) begin
          state_d  = UNLOCKED;
          rr_ptr_d = next_idx(grant_q);
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Lock FSM registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= UNLOCKED;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FIFO pointers and occupancy; resetting them discards any buffered flits.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_flit;
  end

  assign fout_valid_o = !fifo_empty;
  assign fout_data_o  = fifo_empty ? '0 : mem[rd_ptr_q];
  assign lock_o       = (state_q == LOCKED);
  assign grant_o      = grant_q;

endmodule
